// File: rtl/icache_pkg.sv
// Shared types, sizes and state encodings for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned INDEX_BITS = 8;
  localparam int unsigned TAG_BITS   = ADDR_W - 2 - INDEX_BITS;
  localparam int unsigned LINES      = 2 ** INDEX_BITS;

  localparam logic [0:0] IC_IDLE = 1'b0;
  localparam logic [0:0] IC_MISS = 1'b1;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [INSTR_W-1:0]    instr_t;
  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]   tag_t;

  typedef struct packed {
    tag_t   tag;
    instr_t data;
  } line_t;

  function automatic idx_t addr_idx(input addr_t a);
    return a[INDEX_BITS+1:2];
  endfunction

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1:INDEX_BITS+2];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: synchronous single-port write, combinational read.
module icache_array
  import icache_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  idx_t  widx,
  input  line_t wline,
  input  idx_t  ridx,
  output logic  rvalid_c,
  output line_t rline_c
);

  logic [LINES-1:0] valid;
  line_t            lines [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag/data need no reset: an entry is only consulted while its valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      lines[widx] <= wline;
    end
  end

  assign rvalid_c = valid[ridx];
  assign rline_c  = lines[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
module icache
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               icache_enable,
  input  logic [ADDR_W-1:0]  pc_to_fetch,
  output logic [INSTR_W-1:0] instr_fetched,
  output logic               icache_success,
  output logic [ADDR_W-1:0]  success_pc,
  output logic               mc_enable,
  output logic [ADDR_W-1:0]  mc_addr,
  input  logic [INSTR_W-1:0] mc_instr,
  input  logic               mc_success
);

  logic [0:0] state, state_n;
  addr_t      miss_pc, miss_pc_n;
  logic       drop, drop_n;
  logic       success_n;
  instr_t     instr_n;
  addr_t      success_pc_n;
  logic       mc_enable_n;
  addr_t      mc_addr_n;
  logic       fill_c;
  logic       rvalid_c;
  line_t      rline_c;
  logic       hit_c;

  icache_array u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (fill_c & rdy & ~rst),
    .widx     (addr_idx(miss_pc)),
    .wline    ('{tag: addr_tag(miss_pc), data: mc_instr}),
    .ridx     (addr_idx(pc_to_fetch)),
    .rvalid_c (rvalid_c),
    .rline_c  (rline_c)
  );

  assign hit_c = rvalid_c && (rline_c.tag == addr_tag(pc_to_fetch));

  // Next-state and next-output logic; all results land in registers below.
  always_comb begin
    state_n      = state;
    miss_pc_n    = miss_pc;
    drop_n       = drop;
    success_n    = 1'b0;
    instr_n      = instr_fetched;
    success_pc_n = success_pc;
    mc_enable_n  = mc_enable;
    mc_addr_n    = mc_addr;
    fill_c       = 1'b0;
    case (state)
      IC_IDLE: begin
        if (!clear && icache_enable) begin
          if (hit_c) begin
            success_n    = 1'b1;
            instr_n      = rline_c.data;
            success_pc_n = pc_to_fetch;
          end else begin
            state_n     = IC_MISS;
            mc_enable_n = 1'b1;
            mc_addr_n   = {pc_to_fetch[ADDR_W-1:2], 2'b00};
            miss_pc_n   = pc_to_fetch;
          end
        end
      end
      IC_MISS: begin
        if (mc_success) begin
          // The fill always completes; a flush only suppresses the answer.
          fill_c      = 1'b1;
          mc_enable_n = 1'b0;
          state_n     = IC_IDLE;
          drop_n      = 1'b0;
          if (!drop && !clear) begin
            success_n    = 1'b1;
            instr_n      = mc_instr;
            success_pc_n = miss_pc;
          end
        end else if (clear) begin
          drop_n = 1'b1;
        end
      end
      default: state_n = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IC_IDLE;
      miss_pc        <= '0;
      drop           <= 1'b0;
      icache_success <= 1'b0;
      instr_fetched  <= '0;
      success_pc     <= '0;
      mc_enable      <= 1'b0;
      mc_addr        <= '0;
    end else if (rdy) begin
      state          <= state_n;
      miss_pc        <= miss_pc_n;
      drop           <= drop_n;
      icache_success <= success_n;
      instr_fetched  <= instr_n;
      success_pc     <= success_pc_n;
      mc_enable      <= mc_enable_n;
      mc_addr        <= mc_addr_n;
    end
  end

endmodule
